idct_pass_scheduler: RTL and testbench

- Sequences the two-pass 8x8 inverse-DCT datapath: row pass (input block memory × C, results to temp RAM), then column pass (temp RAM × C', results to output memory).
- Generates i/j addresses, mux selects, write enables with matched read latency, block-level handshakes and downstream backpressure.
- Processes N_BLK consecutive blocks per start.
- Sits between the frame-level control and the IDCT datapath.

---
 rtl/idct_pass_scheduler.sv | 179 +++++++++++++++++
 tb/tb_idct_pass_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/idct_pass_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : idct_pass_scheduler                                               |
// | Desc   : Sequences the row and column passes of an 8x8 inverse DCT:        |
// |          address generation, source/coef selects, latency-matched write    |
// |          strobes, block handshakes and downstream backpressure.            |
// |          Optional: define IDCT_STALL_CNT_EN to add the stall_cnt output.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module idct_pass_scheduler #(
  parameter int RD_LAT = 1,
  parameter int N_BLK  = 1,
  parameter int BLK_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic             out_ready,
  output logic             in_release,
  output logic [2:0]       out_i,
  output logic [2:0]       out_j,
  output logic [2:0]       wr_i,
  output logic [2:0]       wr_j,
  output logic             sel_src,
  output logic             sel_coef,
  output logic             wen_temp,
  output logic             wen_out,
  output logic [BLK_W-1:0] blk_idx,
  output logic             busy,
  output logic             done
`ifdef IDCT_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_WAIT_IN = 3'd1;
  localparam logic [2:0] c_ROW     = 3'd2;
  localparam logic [2:0] c_DRAIN_R = 3'd3;
  localparam logic [2:0] c_COL     = 3'd4;
  localparam logic [2:0] c_DRAIN_C = 3'd5;
  localparam logic [2:0] c_FIN     = 3'd6;

  localparam logic [1:0]       c_DRAIN_LAST = (RD_LAT > 0) ? 2'(RD_LAT - 1) : 2'd0;
  localparam logic [BLK_W-1:0] c_BLK_LAST   = BLK_W'(N_BLK - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [2:0]       r_i;
  logic [2:0]       r_j;
  logic [BLK_W-1:0] r_blk;
  logic [1:0]       r_drain;

  logic       w_in_col;
  logic       w_issue;
  logic       w_last;
  logic       w_drain_last;
  logic       w_drain_step;
  logic       w_adv;
  logic       w_blk_adv;
  logic [2:0] w_blk_end_state;
  logic [7:0] w_entry;
  logic [7:0] w_wr;

  assign w_in_col        = (r_state == c_COL) || (r_state == c_DRAIN_C);
  assign w_issue         = (r_state == c_ROW) || ((r_state == c_COL) && out_ready);
  assign w_last          = (r_i == 3'd7) && (r_j == 3'd7);
  assign w_drain_last    = (r_drain == c_DRAIN_LAST);
  assign w_drain_step    = (r_state == c_DRAIN_R) || ((r_state == c_DRAIN_C) && out_ready);
  assign w_blk_end_state = (r_blk == c_BLK_LAST) ? c_FIN : c_WAIT_IN;
  // Backpressure only freezes the column pass; the row pass always streams.
  assign w_adv           = !(w_in_col && !out_ready);
  assign w_blk_adv       = w_in_col && (w_state_nxt == c_WAIT_IN);

  // Pipeline entry: {valid, pass (1 = column), i, j}
  assign w_entry = {w_issue, (r_state == c_COL), r_i, r_j};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:    if (start)        w_state_nxt = c_WAIT_IN;
      c_WAIT_IN: if (in_valid)     w_state_nxt = c_ROW;
      c_ROW:     if (w_last)       w_state_nxt = (RD_LAT == 0) ? c_COL : c_DRAIN_R;
      c_DRAIN_R: if (w_drain_last) w_state_nxt = c_COL;
      c_COL: begin
        if (out_ready && w_last)
          w_state_nxt = (RD_LAT == 0) ? w_blk_end_state : c_DRAIN_C;
      end
      c_DRAIN_C: if (out_ready && w_drain_last) w_state_nxt = w_blk_end_state;
      c_FIN:     w_state_nxt = c_IDLE;
      default:   w_state_nxt = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
      r_i     <= 3'd0;
      r_j     <= 3'd0;
      r_blk   <= '0;
      r_drain <= 2'd0;
    end else begin
      r_state <= w_state_nxt;

      if ((r_state == c_IDLE) && start)
        r_blk <= '0;
      else if (w_blk_adv)
        r_blk <= r_blk + BLK_W'(1);

      // j runs fastest; (7,7) wraps naturally back to (0,0) for the next pass
      if (w_issue) begin
        r_j <= r_j + 3'd1;
        if (r_j == 3'd7)
          r_i <= r_i + 3'd1;
      end else if ((r_state == c_IDLE) || (r_state == c_WAIT_IN)) begin
        r_i <= 3'd0;
        r_j <= 3'd0;
      end

      if (w_drain_step)
        r_drain <= w_drain_last ? 2'd0 : r_drain + 2'd1;
      else if ((r_state != c_DRAIN_R) && (r_state != c_DRAIN_C))
        r_drain <= 2'd0;
    end
  end

  generate
    if (RD_LAT == 0) begin : g_no_pipe
      assign w_wr = w_entry;
    end else begin : g_pipe
      logic [RD_LAT-1:0][7:0] r_pipe;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_pipe <= '0;
        end else if (w_adv) begin
          for (int k = RD_LAT - 1; k > 0; k--)
            r_pipe[k] <= r_pipe[k-1];
          r_pipe[0] <= w_entry;
        end
      end

      assign w_wr = r_pipe[RD_LAT-1];
    end
  endgenerate

  assign wen_temp   = w_wr[7] && !w_wr[6];
  assign wen_out    = w_wr[7] && w_wr[6] && out_ready;
  assign wr_i       = w_wr[5:3];
  assign wr_j       = w_wr[2:0];
  assign in_release = wen_temp && (w_wr[5:0] == 6'h3F);

  assign out_i    = r_i;
  assign out_j    = r_j;
  assign sel_src  = w_in_col;
  assign sel_coef = w_in_col;
  assign blk_idx  = r_blk;
  assign busy     = (r_state != c_IDLE);
  assign done     = (r_state == c_FIN);

`ifdef IDCT_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= 16'd0;
    else if ((r_state == c_IDLE) && start)
      r_stall_cnt <= 16'd0;
    else if (w_in_col && !out_ready && (r_stall_cnt != 16'hFFFF))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_idct_pass_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_idct_pass_scheduler                                            |
// | Desc   : Directed bench for idct_pass_scheduler (three configurations).    |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_idct_pass_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       in_valid;
  logic       out_ready;
  logic [1:0] dut_sel;
  int         n_tests;
  int         n_fail;

  // {in_release, out_i, out_j, wr_i, wr_j, sel_src, sel_coef, wen_temp, wen_out, blk_idx, busy, done}
  wire [34:0] dv [3];
`ifdef IDCT_STALL_CNT_EN
  wire [15:0] scnt [3];
`endif

  // instance 0: RD_LAT=1 N_BLK=1, instance 1: RD_LAT=1 N_BLK=3, instance 2: RD_LAT=0 N_BLK=1
  generate
    for (genvar d = 0; d < 3; d++) begin : g_dut
      idct_pass_scheduler #(
        .RD_LAT ((d == 2) ? 0 : 1),
        .N_BLK  ((d == 1) ? 3 : 1),
        .BLK_W  (16)
      ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start && (dut_sel == 2'(d))),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .in_release (dv[d][34]),
        .out_i      (dv[d][33:31]),
        .out_j      (dv[d][30:28]),
        .wr_i       (dv[d][27:25]),
        .wr_j       (dv[d][24:22]),
        .sel_src    (dv[d][21]),
        .sel_coef   (dv[d][20]),
        .wen_temp   (dv[d][19]),
        .wen_out    (dv[d][18]),
        .blk_idx    (dv[d][17:2]),
        .busy       (dv[d][1]),
        .done       (dv[d][0])
`ifdef IDCT_STALL_CNT_EN
        ,
        .stall_cnt  (scnt[d])
`endif
      );
    end
  endgenerate

  wire [34:0] m_vec        = dv[dut_sel];
  wire        m_in_release = m_vec[34];
  wire [2:0]  m_out_i      = m_vec[33:31];
  wire [2:0]  m_out_j      = m_vec[30:28];
  wire [2:0]  m_wr_i       = m_vec[27:25];
  wire [2:0]  m_wr_j       = m_vec[24:22];
  wire        m_sel_src    = m_vec[21];
  wire        m_sel_coef   = m_vec[20];
  wire        m_wen_temp   = m_vec[19];
  wire        m_wen_out    = m_vec[18];
  wire [15:0] m_blk_idx    = m_vec[17:2];
  wire        m_busy       = m_vec[1];
  wire        m_done       = m_vec[0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // Cycle k is the period following clock edge k-1, where edge 0 samples start.
  task automatic run_scn(input string tag, input logic [1:0] sel, input int nblk, input int lat,
                         input bit do_stall, input bit do_inv, input bit do_rst, input bit do_restart,
                         input int exp_done, input int exp_temp1, input int exp_rel1, input int exp_col1);
    int k = 0;
    int n_temp = 0, n_out = 0, n_rel = 0;
    int first_temp = -1, first_rel = -1, first_col = -1, done_cyc = -1, done_blk = -1;
    int ord_err = 0, lag_err = 0, blk_err = 0, stall_err = 0, sel_err = 0;
    int stall_left = 0, inv_left = 0;
    bit stall_used = 0, inv_used = 0, fin = 0, rst_hit = 0;
    logic [2:0] prev_i = 3'd0, prev_j = 3'd0;

    dut_sel   = sel;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    while (!fin && k < 1000) begin
      @(negedge clk);
      k++;
      start = do_restart && (k == 50 || k == 100);

      if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) out_ready = 1'b1;
      end else if (do_stall && !stall_used && m_sel_src && m_out_i == 3'd3 && m_out_j == 3'd5) begin
        out_ready  = 1'b0;
        stall_left = 10;
        stall_used = 1'b1;
      end

      if (inv_left > 0) begin
        inv_left--;
        if (inv_left == 0) in_valid = 1'b1;
      end else if (do_inv && !inv_used && m_blk_idx == 16'd2) begin
        in_valid = 1'b0;
        inv_left = 5;
        inv_used = 1'b1;
      end

      if (do_rst && m_sel_src && m_out_i == 3'd4 && m_out_j == 3'd2) begin
        rst_n = 1'b0;
        #1;
        chk({tag, "_outputs_zero"}, 64'(m_vec), 64'd0);
        rst_hit = 1'b1;
        fin     = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        #1;
        if (m_sel_src != m_sel_coef) sel_err++;
        if (m_sel_src && first_col < 0) first_col = k;
        if (m_wen_temp) begin
          if (first_temp < 0) first_temp = k;
          if ({m_wr_i, m_wr_j} != 6'(n_temp)) ord_err++;
          if (lat == 0) begin
            if ({m_wr_i, m_wr_j} != {m_out_i, m_out_j}) lag_err++;
          end else if ({m_wr_i, m_wr_j} != {prev_i, prev_j}) lag_err++;
          n_temp++;
        end
        if (m_wen_out) begin
          if ({m_wr_i, m_wr_j} != 6'(n_out)) ord_err++;
          if (lat == 0 && {m_wr_i, m_wr_j} != {m_out_i, m_out_j}) lag_err++;
          n_out++;
        end
        if (m_in_release) begin
          if (first_rel < 0) first_rel = k;
          if (m_blk_idx != 16'(n_rel)) blk_err++;
          n_rel++;
        end
        if (stall_left > 0 && ({m_out_i, m_out_j} != 6'o35 || m_wen_out)) stall_err++;
        prev_i = m_out_i;
        prev_j = m_out_j;
        if (m_done) begin
          done_cyc = k;
          done_blk = int'(m_blk_idx);
          fin      = 1'b1;
        end
      end
    end

    if (do_rst) begin
      chk({tag, "_reached_4_2"}, 64'(rst_hit), 64'd1);
    end else begin
      chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
      chk({tag, "_first_wen_temp"}, 64'(first_temp), 64'(exp_temp1));
      chk({tag, "_in_release_cycle"}, 64'(first_rel), 64'(exp_rel1));
      chk({tag, "_first_col"}, 64'(first_col), 64'(exp_col1));
      chk({tag, "_wen_temp_cnt"}, 64'(n_temp), 64'(64 * nblk));
      chk({tag, "_wen_out_cnt"}, 64'(n_out), 64'(64 * nblk));
      chk({tag, "_in_release_cnt"}, 64'(n_rel), 64'(nblk));
      chk({tag, "_addr_order_errs"}, 64'(ord_err), 64'd0);
      chk({tag, "_addr_lag_errs"}, 64'(lag_err), 64'd0);
      chk({tag, "_blk_idx_errs"}, 64'(blk_err), 64'd0);
      chk({tag, "_sel_errs"}, 64'(sel_err), 64'd0);
      chk({tag, "_blk_at_done"}, 64'(done_blk), 64'(nblk - 1));
      if (do_stall) begin
        chk({tag, "_stall_used"}, 64'(stall_used), 64'd1);
        chk({tag, "_stall_errs"}, 64'(stall_err), 64'd0);
      end
      @(negedge clk);
      #1;
      chk({tag, "_idle_after"}, 64'({m_busy, m_done}), 64'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    dut_sel   = 2'd0;
    n_tests   = 0;
    n_fail    = 0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      dut_sel = 2'(d);
      #1;
      chk("reset_state", 64'(m_vec), 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    //       tag      sel nblk lat stall inv rst restart done tmp1 rel1 col1
    run_scn("base",  2'd0, 1, 1,  0,    0,  0,  0,     132, 3,   66,  67);
    run_scn("stall", 2'd0, 1, 1,  1,    0,  0,  0,     142, 3,   66,  67);
    run_scn("multi", 2'd1, 3, 1,  0,    1,  0,  0,     399, 3,   66,  67);
    run_scn("lat0",  2'd2, 1, 0,  0,    0,  0,  0,     130, 2,   65,  66);
    run_scn("rst",   2'd0, 1, 1,  0,    0,  1,  0,     0,   0,   0,   0);
    run_scn("rerun", 2'd0, 1, 1,  0,    0,  0,  1,     132, 3,   66,  67);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
